// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage for the RV64I pipeline: load extraction, RF write port, retire counter.
// Optional macro MEM_WB_BYPASS_EN adds a combinational WB->decode operand bypass.
module mem_wb_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memtoreg,
  input  logic [2:0]       mem_funct3,
  input  logic [2:0]       mem_addr_lo,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_data,
  input  logic             stall,
  input  logic             flush,
  output logic [4:0]       wb_wr_addr,
  output logic [XLEN-1:0]  wb_wrdata,
  output logic             wb_wr_en,
  output logic             wb_valid,
  output logic             wb_misalign,
  output logic [CNT_W-1:0] retire_cnt
`ifdef MEM_WB_BYPASS_EN
  ,
  input  logic [4:0]       dec_rs1_addr,
  input  logic [4:0]       dec_rs2_addr,
  input  logic [XLEN-1:0]  rf_rdata1,
  input  logic [XLEN-1:0]  rf_rdata2,
  output logic [XLEN-1:0]  dec_rs1_data,
  output logic [XLEN-1:0]  dec_rs2_data
`endif
);

  // Data arrives already shifted so the addressed byte sits at bit 0.
  function automatic logic [XLEN-1:0] extract_load(input logic [2:0] f3,
                                                   input logic [XLEN-1:0] sh);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = sh[7:0];
    h = sh[15:0];
    w = sh[31:0];
    case (f3)
      3'b000:  extract_load = XLEN'(b);
      3'b001:  extract_load = XLEN'(h);
      3'b010:  extract_load = XLEN'(w);
      3'b100:  extract_load = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  extract_load = {{(XLEN-16){1'b0}}, sh[15:0]};
      3'b110:  extract_load = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: extract_load = sh;
    endcase
  endfunction

  function automatic logic load_misaligned(input logic [2:0] f3, input logic [2:0] off);
    case (f3)
      3'b000, 3'b100: load_misaligned = 1'b0;
      3'b001, 3'b101: load_misaligned = off[0];
      3'b010, 3'b110: load_misaligned = |off[1:0];
      3'b011:         load_misaligned = |off;
      default:        load_misaligned = 1'b1;
    endcase
  endfunction

  logic [4:0]       wb_wr_addr_d,  wb_wr_addr_q;
  logic [XLEN-1:0]  wb_wrdata_d,   wb_wrdata_q;
  logic             wb_wr_en_d,    wb_wr_en_q;
  logic             wb_valid_d,    wb_valid_q;
  logic             wb_misalign_d, wb_misalign_q;
  logic [CNT_W-1:0] retire_cnt_d,  retire_cnt_q;

  logic [XLEN-1:0]  load_shifted;
  logic             misalign;
  logic [XLEN-1:0]  result;

  always_comb begin
    load_shifted = mem_load_data >> {mem_addr_lo, 3'b000};
    misalign     = mem_valid & mem_memtoreg & load_misaligned(mem_funct3, mem_addr_lo);
    if (!mem_memtoreg)
      result = mem_alu_result;
    else if (misalign)
      result = '0;
    else
      result = extract_load(mem_funct3, load_shifted);

    wb_wr_addr_d  = wb_wr_addr_q;
    wb_wrdata_d   = wb_wrdata_q;
    wb_wr_en_d    = wb_wr_en_q;
    wb_valid_d    = wb_valid_q;
    wb_misalign_d = wb_misalign_q;
    retire_cnt_d  = retire_cnt_q;

    if (flush) begin
      wb_wr_addr_d  = '0;
      wb_wrdata_d   = '0;
      wb_wr_en_d    = 1'b0;
      wb_valid_d    = 1'b0;
      wb_misalign_d = 1'b0;
    end else if (!stall) begin
      wb_wr_addr_d  = mem_rd;
      wb_wrdata_d   = result;
      wb_wr_en_d    = mem_valid & mem_regwrite & (mem_rd != 5'd0) & ~misalign;
      wb_valid_d    = mem_valid;
      wb_misalign_d = misalign;
      retire_cnt_d  = retire_cnt_q + CNT_W'(mem_valid);
    end
  end

  // MEM -> WB register boundary
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wb_wr_addr_q  <= '0;
      wb_wrdata_q   <= '0;
      wb_wr_en_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_misalign_q <= 1'b0;
      retire_cnt_q  <= '0;
    end else begin
      wb_wr_addr_q  <= wb_wr_addr_d;
      wb_wrdata_q   <= wb_wrdata_d;
      wb_wr_en_q    <= wb_wr_en_d;
      wb_valid_q    <= wb_valid_d;
      wb_misalign_q <= wb_misalign_d;
      retire_cnt_q  <= retire_cnt_d;
    end
  end

  assign wb_wr_addr  = wb_wr_addr_q;
  assign wb_wrdata   = wb_wrdata_q;
  assign wb_wr_en    = wb_wr_en_q;
  assign wb_valid    = wb_valid_q;
  assign wb_misalign = wb_misalign_q;
  assign retire_cnt  = retire_cnt_q;

`ifdef MEM_WB_BYPASS_EN
  // The RF commits at the edge, so a same-cycle read must see the pending write.
  assign dec_rs1_data = (wb_wr_en_q && (dec_rs1_addr == wb_wr_addr_q)) ? wb_wrdata_q : rf_rdata1;
  assign dec_rs2_data = (wb_wr_en_q && (dec_rs2_addr == wb_wr_addr_q)) ? wb_wrdata_q : rf_rdata2;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage: extraction, misalign, x0, stall/flush, async reset, optional bypass.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        nrst;
  logic        mem_valid, mem_regwrite, mem_memtoreg;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3, mem_addr_lo;
  logic [63:0] mem_alu_result, mem_load_data;
  logic        stall, flush;
  logic [4:0]  wb_wr_addr;
  logic [63:0] wb_wrdata;
  logic        wb_wr_en, wb_valid, wb_misalign;
  logic [63:0] retire_cnt;
`ifdef MEM_WB_BYPASS_EN
  logic [4:0]  dec_rs1_addr, dec_rs2_addr;
  logic [63:0] rf_rdata1, rf_rdata2, dec_rs1_data, dec_rs2_data;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] LD_PAT = 64'h8877_6655_4433_22F1;

  mem_wb_stage #(.XLEN(64), .CNT_W(64)) dut (
    .clk(clk), .nrst(nrst),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_memtoreg(mem_memtoreg), .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .stall(stall), .flush(flush),
    .wb_wr_addr(wb_wr_addr), .wb_wrdata(wb_wrdata), .wb_wr_en(wb_wr_en),
    .wb_valid(wb_valid), .wb_misalign(wb_misalign), .retire_cnt(retire_cnt)
`ifdef MEM_WB_BYPASS_EN
    ,
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic m2r,
                       input logic [2:0] f3, input logic [2:0] lo, input logic [63:0] alu);
    mem_valid      = v;
    mem_rd         = rd;
    mem_regwrite   = rw;
    mem_memtoreg   = m2r;
    mem_funct3     = f3;
    mem_addr_lo    = lo;
    mem_alu_result = alu;
  endtask

  task automatic check_wb(input string tag, input logic [63:0] data, input logic en,
                          input logic vld, input logic mis, input logic [63:0] cnt);
    check({tag, ".data"}, wb_wrdata, data);
    check({tag, ".en"},   64'(wb_wr_en), 64'(en));
    check({tag, ".vld"},  64'(wb_valid), 64'(vld));
    check({tag, ".mis"},  64'(wb_misalign), 64'(mis));
    check({tag, ".cnt"},  retire_cnt, cnt);
  endtask

  initial begin
    nrst = 1'b0; stall = 1'b0; flush = 1'b0;
    mem_load_data = LD_PAT;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 64'd0);
`ifdef MEM_WB_BYPASS_EN
    dec_rs1_addr = 5'd0; dec_rs2_addr = 5'd0; rf_rdata1 = 64'd0; rf_rdata2 = 64'd0;
`endif
    #3;
    check("rst.addr", 64'(wb_wr_addr), 64'd0);
    check_wb("rst", 64'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    step(); step();
    #2 nrst = 1'b1;

    // ALU result
    drive(1'b1, 5'd5, 1'b1, 1'b0, 3'd0, 3'd3, 64'h1234);
    step();
    check("alu.addr", 64'(wb_wr_addr), 64'd5);
    check_wb("alu", 64'h1234, 1'b1, 1'b1, 1'b0, 64'd1);

    // Load extraction
    drive(1'b1, 5'd6, 1'b1, 1'b1, 3'b000, 3'd0, 64'd0); step();
    check_wb("lb", 64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 1'b1, 1'b0, 64'd2);
    drive(1'b1, 5'd6, 1'b1, 1'b1, 3'b100, 3'd0, 64'd0); step();
    check_wb("lbu", 64'h0000_0000_0000_00F1, 1'b1, 1'b1, 1'b0, 64'd3);
    drive(1'b1, 5'd6, 1'b1, 1'b1, 3'b010, 3'd4, 64'd0); step();
    check_wb("lw4", 64'hFFFF_FFFF_8877_6655, 1'b1, 1'b1, 1'b0, 64'd4);
    drive(1'b1, 5'd6, 1'b1, 1'b1, 3'b110, 3'd4, 64'd0); step();
    check_wb("lwu4", 64'h0000_0000_8877_6655, 1'b1, 1'b1, 1'b0, 64'd5);
    drive(1'b1, 5'd6, 1'b1, 1'b1, 3'b001, 3'd2, 64'd0); step();
    check("lh2.data", wb_wrdata, 64'h0000_0000_0000_4433);
    drive(1'b1, 5'd6, 1'b1, 1'b1, 3'b001, 3'd6, 64'd0); step();
    check("lh6.data", wb_wrdata, 64'hFFFF_FFFF_FFFF_8877);
    drive(1'b1, 5'd6, 1'b1, 1'b1, 3'b101, 3'd6, 64'd0); step();
    check("lhu6.data", wb_wrdata, 64'h0000_0000_0000_8877);
    drive(1'b1, 5'd6, 1'b1, 1'b1, 3'b100, 3'd7, 64'd0); step();
    check("lbu7.data", wb_wrdata, 64'h0000_0000_0000_0088);
    drive(1'b1, 5'd6, 1'b1, 1'b1, 3'b011, 3'd0, 64'd0); step();
    check_wb("ld", LD_PAT, 1'b1, 1'b1, 1'b0, 64'd10);

    // Misaligned and illegal loads
    drive(1'b1, 5'd6, 1'b1, 1'b1, 3'b001, 3'd3, 64'd0); step();
    check_wb("lh3", 64'd0, 1'b0, 1'b1, 1'b1, 64'd11);
    drive(1'b1, 5'd6, 1'b1, 1'b1, 3'b111, 3'd0, 64'd0); step();
    check_wb("f3_7", 64'd0, 1'b0, 1'b1, 1'b1, 64'd12);
    drive(1'b1, 5'd6, 1'b1, 1'b1, 3'b011, 3'd4, 64'd0); step();
    check_wb("ld4", 64'd0, 1'b0, 1'b1, 1'b1, 64'd13);
    drive(1'b1, 5'd6, 1'b1, 1'b1, 3'b010, 3'd2, 64'd0); step();
    check_wb("lw2", 64'd0, 1'b0, 1'b1, 1'b1, 64'd14);

    // x0 destination and bubble
    drive(1'b1, 5'd0, 1'b1, 1'b0, 3'd0, 3'd0, 64'hDEAD); step();
    check_wb("x0", 64'hDEAD, 1'b0, 1'b1, 1'b0, 64'd15);
    drive(1'b0, 5'd3, 1'b1, 1'b0, 3'd0, 3'd0, 64'h77); step();
    check_wb("bubble", 64'h77, 1'b0, 1'b0, 1'b0, 64'd15);
    drive(1'b1, 5'd4, 1'b0, 1'b0, 3'd0, 3'd0, 64'h99); step();
    check_wb("norw", 64'h99, 1'b0, 1'b1, 1'b0, 64'd16);

    // Stall holds everything for three cycles
    drive(1'b1, 5'd9, 1'b1, 1'b0, 3'd0, 3'd0, 64'h55); step();
    check_wb("pre_stall", 64'h55, 1'b1, 1'b1, 1'b0, 64'd17);
    stall = 1'b1;
    drive(1'b1, 5'd12, 1'b1, 1'b1, 3'b111, 3'd0, 64'hAA);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.addr", 64'(wb_wr_addr), 64'd9);
      check_wb("stall", 64'h55, 1'b1, 1'b1, 1'b0, 64'd17);
    end

    // Stall + flush: flush wins, no count
    flush = 1'b1; step();
    check("sf.addr", 64'(wb_wr_addr), 64'd0);
    check_wb("sf", 64'd0, 1'b0, 1'b0, 1'b0, 64'd17);
    stall = 1'b0; flush = 1'b0;

    // Bypass: x7 <= 0xABCD pending in WB
    drive(1'b1, 5'd7, 1'b1, 1'b0, 3'd0, 3'd0, 64'hABCD); step();
    check_wb("x7", 64'hABCD, 1'b1, 1'b1, 1'b0, 64'd18);
`ifdef MEM_WB_BYPASS_EN
    dec_rs1_addr = 5'd7; rf_rdata1 = 64'h1;
    dec_rs2_addr = 5'd0; rf_rdata2 = 64'h22;
    #1;
    check("byp.rs1", dec_rs1_data, 64'hABCD);
    check("byp.rs2", dec_rs2_data, 64'h22);
    dec_rs2_addr = 5'd8; #1;
    check("byp.rs2b", dec_rs2_data, 64'h22);
`endif

    // Async reset mid-stall
    stall = 1'b1; step();
    check("pre_rst.cnt", retire_cnt, 64'd18);
    #2 nrst = 1'b0;
    #1;
    check("mrst.addr", 64'(wb_wr_addr), 64'd0);
    check_wb("mrst", 64'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    step();
    check("mrst_hold.cnt", retire_cnt, 64'd0);
    #2 nrst = 1'b1; stall = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 1'b0, 3'd0, 3'd0, 64'h5A5A);
    step();
    check_wb("post_rst", 64'h5A5A, 1'b1, 1'b1, 1'b0, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback stage of the 64-bit RV64I pipeline.
- Captures memory-stage results each cycle and performs little-endian load-data extraction with sign/zero extension.
- Drives the general-purpose register file write port: wr_addr, wrdata, wr_en.
- Keeps a retired-instruction counter and flags misaligned loads.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- mem_valid  in  1  MEM stage holds a real instruction
- mem_rd  in  5  destination register index
- mem_regwrite  in  1  instruction writes rd
- mem_memtoreg  in  1  1 = result from load data, 0 = result from ALU
- mem_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 illegal
- mem_addr_lo  in  3  effective address bits [2:0]
- mem_alu_result  in  64  ALU/PC+4 result
- mem_load_data  in  64  raw aligned doubleword from data memory
- stall  in  1  hold WB register contents
- flush  in  1  kill the instruction being captured
- wb_wr_addr  out  5  register file write index
- wb_wrdata  out  64  register file write data
- wb_wr_en  out  1  register file write enable
- wb_valid  out  1  WB holds a real instruction
- wb_misalign  out  1  held instruction was a misaligned or illegal load
- retire_cnt  out  CNT_W  count of instructions captured into WB

Behaviour:
- Reset: nrst low asynchronously clears all state. While reset is held, wb_wr_addr=0, wb_wrdata=0, wb_wr_en=0, wb_valid=0, wb_misalign=0, retire_cnt=0.
- Capture priority at each rising edge: flush > stall > load.
  - flush=1: wb_valid<=0 and wb_wr_en<=0. Other fields are don't-care; they are cleared to 0.
  - stall=1 with flush=0: every WB register holds its value. The held write repeats on the register file, which is harmless.
  - Otherwise: capture. wb_valid<=mem_valid.
- Latency: exactly one cycle from MEM inputs to WB outputs. All outputs are registered; no combinational path from inputs to outputs.
- Load extraction applies when mem_memtoreg=1:
  - Byte offset = mem_addr_lo; shift amount = offset*8.
  - LB/LBU take byte [offset].
  - LH/LHU take the halfword at offset. They require offset[0]=0.
  - LW/LWU take the word at offset. They require offset[1:0]=0.
  - LD requires offset=0.
  - Signed types sign-extend from the loaded MSB to 64 bits. Unsigned types zero-extend.
- Misalign: set when a requirement above fails, or funct3=111, with mem_memtoreg=1 and mem_valid=1.
  - Captured into wb_misalign.
  - Forces the captured wb_wr_en=0; wb_wrdata captured as 0.
- When mem_memtoreg=0: wrdata = mem_alu_result and no alignment check.
- wb_wr_en (captured) = mem_valid & mem_regwrite & (mem_rd!=0) & ~misalign.
  - Writes to x0 are never enabled, even though the register file also protects x0.
- wb_wr_addr captures mem_rd unconditionally on capture edges.
- retire_cnt:
  - Increments by 1 on an edge where capture happens (flush=0, stall=0) with mem_valid=1.
  - Misaligned loads count.
  - Wraps modulo 2^CNT_W with no saturation.
- Simultaneous stall and flush: flush wins and the counter does not increment.
- Reset asserted mid-stall or mid-flush: immediate clear. First capture happens on the first rising edge after nrst deasserts.

Optional Feature:
- Macro: MEM_WB_BYPASS_EN.
- When defined, add these ports:
  - dec_rs1_addr in 5, dec_rs2_addr in 5: decode-stage source register indices.
  - rf_rdata1 in 64, rf_rdata2 in 64: register file read data.
  - dec_rs1_data out 64, dec_rs2_data out 64: bypassed operands.
- Bypass rule, purely combinational:
  - dec_rsN_data = wb_wrdata when wb_wr_en=1 and dec_rsN_addr==wb_wr_addr. The condition wb_wr_addr!=0 is already implied by wb_wr_en.
  - Otherwise dec_rsN_data = rf_rdataN.
- Purpose: closes the same-cycle write/read hazard, since the register file updates only at the clock edge.
- When the macro is undefined, these ports and the logic do not exist. Decode reads the register file directly.

Test Plan:
- Reset, then ALU op: mem_valid=1, mem_regwrite=1, mem_memtoreg=0, rd=5, alu=0x1234 -> next cycle wb_wr_en=1, wb_wr_addr=5, wb_wrdata=0x1234, retire_cnt=1.
- LB with load_data=0x00000000_0000_80FF_00000000... use load_data=0x8877_6655_4433_22F1 and addr_lo=0:
  - funct3=000 -> wrdata=0xFFFF_FFFF_FFFF_FFF1.
  - funct3=100 -> 0xF1.
  - LW at addr_lo=4 -> 0xFFFF_FFFF_8877_6655.
  - LWU at addr_lo=4 -> 0x8877_6655.
- Misaligned: LH at addr_lo=3 -> wb_misalign=1, wb_wr_en=0, retire_cnt increments. funct3=111 gives the same response.
- x0 write: rd=0, regwrite=1, alu=0xDEAD -> wb_wr_en=0, wb_valid=1.
- Stall/flush:
  - stall=1 for 3 cycles -> outputs frozen, retire_cnt unchanged.
  - stall=1 with flush=1 -> wb_valid=0, counter unchanged.
  - nrst pulsed low mid-stall -> all outputs 0 immediately, before the next edge.
- (MEM_WB_BYPASS_EN) wb writes x7=0xABCD while dec_rs1_addr=7 and rf_rdata1=0x1 -> dec_rs1_data=0xABCD. dec_rs2_addr=0 -> dec_rs2_data=rf_rdata2.
